// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Sequencing controller for a multi-cycle MIPS-subset datapath. It steps each
//   instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath
//   enables and mux selects. Both memories are handshaked. The controller
//   stops at an instruction boundary when start_i drops. It counts retired
//   instructions and traps to HALT on an illegal opcode or a memory timeout.
//
// Ports
//   clk_i, rst_i         clock (rising edge), async active-low reset
//   start_i              run enable, sampled at instruction boundaries
//   op_i                 opcode from IR[31:26], valid from DECODE onward
//   zero_i               ALU zero flag (beq)
//   imem_ack_i/dmem_ack_i  memory acknowledges
//   imem_req_o, ir_we_o, pc_we_o, pc_src_o                    fetch / PC control
//   reg_we_o, reg_dst_o, mem_to_reg_o, alu_src_o, alu_op_o   datapath control
//   dmem_req_o, dmem_we_o                                     data memory control
//   busy_o, err_o, state_o, retired_o                         status
module multicycle_ctrl #(
  parameter int WAIT_MAX = 255,
  parameter int CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [5:0]       op_i,
  input  logic             zero_i,
  input  logic             imem_ack_i,
  input  logic             dmem_ack_i,
  output logic             imem_req_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic [1:0]       pc_src_o,
  output logic             reg_we_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             alu_src_o,
  output logic [1:0]       alu_op_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
    S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  // The trap fires on the cycle whose missed ack would bring the count to
  // WAIT_MAX, so an ack in that same cycle still wins.
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_t     state, state_nx;
  logic [7:0] wait_cnt;
  logic       boundary, trap, waiting;

  always_comb begin
    state_nx     = state;
    boundary     = 1'b0;
    trap         = 1'b0;
    waiting      = 1'b0;
    imem_req_o   = 1'b0;
    ir_we_o      = 1'b0;
    pc_we_o      = 1'b0;
    pc_src_o     = 2'b00;
    reg_we_o     = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_o    = 1'b0;
    alu_op_o     = 2'b00;
    dmem_req_o   = 1'b0;
    dmem_we_o    = 1'b0;
    case (state)
      S_IDLE: if (start_i) state_nx = S_FETCH;
      S_FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i) begin
          ir_we_o  = 1'b1;
          pc_we_o  = 1'b1;
          state_nx = S_DECODE;
        end else begin
          waiting = 1'b1;
          trap    = (wait_cnt == WAIT_LAST);
        end
      end
      S_DECODE: begin
        case (op_i)
          OP_J: begin
            pc_we_o  = 1'b1;
            pc_src_o = 2'b10;
            boundary = 1'b1;
          end
          OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_nx = S_EXEC;
          default: trap = 1'b1;
        endcase
      end
      S_EXEC: begin
        case (op_i)
          OP_R: begin
            alu_op_o = 2'b10;
            state_nx = S_WB;
          end
          OP_ADDI: begin
            alu_src_o = 1'b1;
            state_nx  = S_WB;
          end
          OP_LW, OP_SW: begin
            alu_src_o = 1'b1;
            state_nx  = S_MEM;
          end
          OP_BEQ: begin
            alu_op_o = 2'b01;
            pc_src_o = 2'b01;
            pc_we_o  = zero_i;
            boundary = 1'b1;
          end
          default: trap = 1'b1;  // opcode changed under us: treat as illegal
        endcase
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        alu_src_o  = 1'b1;  // keep the effective address stable
        dmem_we_o  = (op_i == OP_SW);
        if (dmem_ack_i) begin
          if (op_i == OP_LW) state_nx = S_WB;
          else               boundary = 1'b1;
        end else begin
          waiting = 1'b1;
          trap    = (wait_cnt == WAIT_LAST);
        end
      end
      S_WB: begin
        reg_we_o     = 1'b1;
        reg_dst_o    = (op_i == OP_R);
        mem_to_reg_o = (op_i == OP_LW);
        // ALU-side selects as in EXEC so the ALU result stays valid.
        if (op_i == OP_R) alu_op_o  = 2'b10;
        else              alu_src_o = 1'b1;
        boundary = 1'b1;
      end
      default: ;  // HALT: everything idle, left only by reset
    endcase
    if (boundary) state_nx = start_i ? S_FETCH : S_IDLE;
    if (trap)     state_nx = S_HALT;
  end

  assign busy_o  = (state != S_IDLE) && (state != S_HALT);
  assign state_o = state;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      err_o     <= 1'b0;
      retired_o <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state) wait_cnt <= '0;
      else if (waiting)      wait_cnt <= wait_cnt + 8'd1;
      if (trap)     err_o     <= 1'b1;
      if (boundary) retired_o <= retired_o + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl. Each step pushes the expected control
// word into a scoreboard queue, and the word is popped and compared on the
// following falling edge.
module tb_multicycle_ctrl;
  localparam int CW = 4;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic [2:0] st;
    logic       imem_req, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       reg_we, reg_dst, mem_to_reg, alu_src;
    logic [1:0] alu_op;
    logic       dmem_req, dmem_we, busy, err;
  } ctl_t;

  logic clk_i = 1'b0, rst_i = 1'b0, start_i = 1'b0, zero_i = 1'b0;
  logic imem_ack_i = 1'b0, dmem_ack_i = 1'b0;
  logic [5:0] op_i = '0;
  logic imem_req_o, ir_we_o, pc_we_o, reg_we_o, reg_dst_o, mem_to_reg_o, alu_src_o;
  logic dmem_req_o, dmem_we_o, busy_o, err_o;
  logic [1:0] pc_src_o, alu_op_o;
  logic [2:0] state_o;
  logic [CW-1:0] retired_o;

  multicycle_ctrl #(.WAIT_MAX(4), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .zero_i(zero_i),
    .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i), .imem_req_o(imem_req_o),
    .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .pc_src_o(pc_src_o), .reg_we_o(reg_we_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .alu_src_o(alu_src_o),
    .alu_op_o(alu_op_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .busy_o(busy_o), .err_o(err_o), .state_o(state_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  ctl_t obs;
  assign obs = {state_o, imem_req_o, ir_we_o, pc_we_o, pc_src_o, reg_we_o, reg_dst_o,
                mem_to_reg_o, alu_src_o, alu_op_o, dmem_req_o, dmem_we_o, busy_o, err_o};

  int n_cmp = 0, n_bad = 0;
  ctl_t sb[$];
  logic [CW-1:0] ret_exp = '0;
  logic err_exp = 1'b0;

  // Control word the datapath should see in a given state.
  function automatic ctl_t ctl(input logic [2:0] st, input logic [5:0] op,
                               input logic z, input logic ia, input logic er);
    ctl_t c;
    c = '0;
    c.st   = st;
    c.err  = er;
    c.busy = (st != 3'd0) && (st != 3'd6);
    case (st)
      3'd1: begin c.imem_req = 1'b1; c.ir_we = ia; c.pc_we = ia; end
      3'd2: if (op == OP_J) begin c.pc_we = 1'b1; c.pc_src = 2'b10; end
      3'd3: begin
        if (op == OP_R) c.alu_op = 2'b10;
        else if (op == OP_BEQ) begin c.alu_op = 2'b01; c.pc_src = 2'b01; c.pc_we = z; end
        else c.alu_src = 1'b1;
      end
      3'd4: begin c.dmem_req = 1'b1; c.alu_src = 1'b1; c.dmem_we = (op == OP_SW); end
      3'd5: begin
        c.reg_we = 1'b1; c.reg_dst = (op == OP_R); c.mem_to_reg = (op == OP_LW);
        if (op == OP_R) c.alu_op = 2'b10; else c.alu_src = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // One clock of directed stimulus, entered and left at posedge+1.
  task automatic step(input string tag, input logic [2:0] st, input logic [5:0] op,
                      input logic z, input logic ia, input logic da, input logic go,
                      input logic bnd, input logic trp);
    ctl_t e;
    op_i = op; zero_i = z; imem_ack_i = ia; dmem_ack_i = da; start_i = go;
    sb.push_back(ctl(st, op, z, ia, err_exp));
    @(negedge clk_i);
    e = sb.pop_front();
    chk({tag, ".ctl"}, 32'(obs), 32'(e));
    chk({tag, ".ret"}, 32'(retired_o), 32'(ret_exp));
    @(posedge clk_i); #1;
    if (bnd) ret_exp = CW'(ret_exp + 1'b1);
    if (trp) err_exp = 1'b1;
  endtask

  initial begin
    // reset held with live-looking inputs: everything must read 0
    start_i = 1'b1; imem_ack_i = 1'b1; dmem_ack_i = 1'b1; op_i = OP_BAD;
    @(negedge clk_i);
    chk("reset.ctl", 32'(obs), 32'd0);
    chk("reset.ret", 32'(retired_o), 32'd0);
    start_i = 1'b0; rst_i = 1'b1;
    @(posedge clk_i); #1;

    // R-type, zero wait: 1,2,3,5 then FETCH
    step("r.idle", 3'd0, OP_R, 0, 0, 0, 1, 0, 0);
    step("r.f",    3'd1, OP_R, 0, 1, 0, 1, 0, 0);
    step("r.d",    3'd2, OP_R, 0, 0, 0, 1, 0, 0);
    step("r.e",    3'd3, OP_R, 0, 0, 0, 1, 0, 0);
    step("r.wb",   3'd5, OP_R, 0, 0, 0, 1, 1, 0);

    // lw with dmem ack delayed 3 cycles: 8 cycles total
    step("lw.f",   3'd1, OP_LW, 0, 1, 0, 1, 0, 0);
    step("lw.d",   3'd2, OP_LW, 0, 0, 0, 1, 0, 0);
    step("lw.e",   3'd3, OP_LW, 0, 0, 0, 1, 0, 0);
    step("lw.m0",  3'd4, OP_LW, 0, 0, 0, 1, 0, 0);
    step("lw.m1",  3'd4, OP_LW, 0, 0, 0, 1, 0, 0);
    step("lw.m2",  3'd4, OP_LW, 0, 0, 0, 1, 0, 0);
    step("lw.m3",  3'd4, OP_LW, 0, 0, 1, 1, 0, 0);
    step("lw.wb",  3'd5, OP_LW, 0, 0, 0, 1, 1, 0);

    // beq taken then not taken
    step("beq1.f", 3'd1, OP_BEQ, 1, 1, 0, 1, 0, 0);
    step("beq1.d", 3'd2, OP_BEQ, 1, 0, 0, 1, 0, 0);
    step("beq1.e", 3'd3, OP_BEQ, 1, 0, 0, 1, 1, 0);
    step("beq0.f", 3'd1, OP_BEQ, 0, 1, 0, 1, 0, 0);
    step("beq0.d", 3'd2, OP_BEQ, 0, 0, 0, 1, 0, 0);
    step("beq0.e", 3'd3, OP_BEQ, 0, 0, 0, 1, 1, 0);

    // sw with start dropped in EXEC: completes, then IDLE
    step("sw.f",   3'd1, OP_SW, 0, 1, 0, 1, 0, 0);
    step("sw.d",   3'd2, OP_SW, 0, 0, 0, 1, 0, 0);
    step("sw.e",   3'd3, OP_SW, 0, 0, 0, 0, 0, 0);
    step("sw.m",   3'd4, OP_SW, 0, 1, 1, 0, 1, 0);
    step("sw.idle", 3'd0, OP_SW, 0, 1, 1, 0, 0, 0);
    step("sw.go",  3'd0, OP_SW, 0, 0, 0, 1, 0, 0);

    // 12 jumps take the 4-bit retired count through its wrap
    for (int i = 0; i < 12; i++) begin
      step("j.f", 3'd1, OP_J, 0, 1, 0, 1, 0, 0);
      step("j.d", 3'd2, OP_J, 0, 0, 0, 1, 1, 0);
    end

    // fetch ack on the 4th cycle (count hits WAIT_MAX): no trap; then addi
    step("w.f0",   3'd1, OP_ADDI, 0, 0, 0, 1, 0, 0);
    step("w.f1",   3'd1, OP_ADDI, 0, 0, 0, 1, 0, 0);
    step("w.f2",   3'd1, OP_ADDI, 0, 0, 0, 1, 0, 0);
    step("w.f3",   3'd1, OP_ADDI, 0, 1, 0, 1, 0, 0);
    step("addi.d", 3'd2, OP_ADDI, 0, 0, 0, 1, 0, 0);
    step("addi.e", 3'd3, OP_ADDI, 0, 0, 0, 1, 0, 0);
    step("addi.wb", 3'd5, OP_ADDI, 0, 0, 0, 1, 1, 0);

    // no fetch ack: HALT after 4 FETCH cycles, sticky
    step("to.f0",  3'd1, OP_R, 0, 0, 0, 1, 0, 0);
    step("to.f1",  3'd1, OP_R, 0, 0, 0, 1, 0, 0);
    step("to.f2",  3'd1, OP_R, 0, 0, 0, 1, 0, 0);
    step("to.f3",  3'd1, OP_R, 0, 0, 0, 1, 0, 1);
    step("to.h0",  3'd6, OP_R, 0, 1, 1, 1, 0, 0);
    step("to.h1",  3'd6, OP_R, 0, 1, 1, 1, 0, 0);

    // asynchronous reset mid-cycle out of HALT
    #2 rst_i = 1'b0;
    #1;
    chk("arst.st",  32'(state_o), 32'd0);
    chk("arst.err", 32'(err_o), 32'd0);
    chk("arst.ret", 32'(retired_o), 32'd0);
    ret_exp = '0; err_exp = 1'b0; start_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;

    // reset in the middle of an instruction
    step("mr.idle", 3'd0, OP_R, 0, 0, 0, 1, 0, 0);
    step("mr.f",    3'd1, OP_R, 0, 1, 0, 1, 0, 0);
    step("mr.d",    3'd2, OP_R, 0, 0, 0, 1, 0, 0);
    #2 rst_i = 1'b0;
    #1;
    chk("mrst.st", 32'(state_o), 32'd0);
    start_i = 1'b0;
    @(negedge clk_i); rst_i = 1'b1;
    @(posedge clk_i); #1;

    // illegal opcode traps in DECODE
    step("il.idle", 3'd0, OP_BAD, 0, 0, 0, 1, 0, 0);
    step("il.f",    3'd1, OP_BAD, 0, 1, 0, 1, 0, 0);
    step("il.d",    3'd2, OP_BAD, 0, 0, 0, 1, 0, 1);
    step("il.h0",   3'd6, OP_BAD, 0, 1, 1, 1, 0, 0);
    step("il.h1",   3'd6, OP_R,   0, 1, 1, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencing controller for the MIPS-subset datapath: PC, instruction register, register file, sign-extend/ALU-source mux, ALU and data memory.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and issues per-state enables and mux selects.
- Handshakes with instruction and data memories, stopping at an instruction boundary when start_i drops.
- Counts retired instructions and traps illegal opcodes and memory timeouts.

Parameters:
WAIT_MAX, 255, max cycles to wait for a memory ack before trapping (1..255)
CNT_W, 32, width of retired-instruction counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-low
start_i  in  1  run enable, sampled at instruction boundaries
op_i  in  6  opcode from instruction register bits [31:26]; valid from DECODE onward
zero_i  in  1  ALU zero flag
imem_ack_i  in  1  instruction memory data valid
dmem_ack_i  in  1  data memory access complete
imem_req_o  out  1  instruction fetch request
ir_we_o  out  1  instruction register load
pc_we_o  out  1  PC write
pc_src_o  out  2  PC source: 00 = PC+4, 01 = branch target, 10 = jump target
reg_we_o  out  1  register file write
reg_dst_o  out  1  destination select: 1 = rd, 0 = rt
mem_to_reg_o  out  1  write-back select: 1 = memory data, 0 = ALU result
alu_src_o  out  1  ALU operand B select: 1 = sign-extended immediate, 0 = rt
alu_op_o  out  2  ALU op: 00 = add, 01 = sub, 10 = use funct field
dmem_req_o  out  1  data memory request
dmem_we_o  out  1  data memory write (valid with dmem_req_o)
busy_o  out  1  1 in any state other than IDLE and HALT
err_o  out  1  sticky trap flag
state_o  out  3  current state: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, HALT = 6
retired_o  out  CNT_W  retired instruction count

Behaviour:
- Reset (rst_i = 0, asynchronous, effective at any point including mid-instruction):
  - state = IDLE, retired_o = 0, err_o = 0, wait counter = 0.
  - All outputs are 0.
- Outputs are decoded combinationally from registered state and op_i. Every output not listed for a state is 0.
- Supported opcodes: R-type 000000, addi 001000, lw 100011, sw 101011, beq 000100, j 000010.
- IDLE: go to FETCH when start_i = 1.
- FETCH: imem_req_o = 1. On imem_ack_i: ir_we_o = 1, pc_we_o = 1, pc_src_o = 00, go to DECODE. Otherwise stay.
- DECODE:
  - Illegal op_i: go to HALT and set err_o.
  - j: pc_we_o = 1, pc_src_o = 10, then boundary.
  - Any other supported opcode: go to EXEC.
- EXEC:
  - R-type: alu_op_o = 10, alu_src_o = 0, go to WB.
  - addi, lw, sw: alu_op_o = 00, alu_src_o = 1. addi goes to WB; lw and sw go to MEM.
  - beq: alu_op_o = 01, alu_src_o = 0, pc_src_o = 01, pc_we_o = zero_i, then boundary.
- MEM:
  - dmem_req_o = 1, alu_op_o = 00, alu_src_o = 1; dmem_we_o = 1 for sw.
  - On dmem_ack_i: lw goes to WB, sw goes to boundary. Otherwise stay.
- WB:
  - reg_we_o = 1.
  - reg_dst_o = 1 for R-type; mem_to_reg_o = 1 for lw.
  - ALU-side controls are held as in EXEC so the ALU result remains valid.
  - Then boundary.
- Boundary (end of the instruction's final state):
  - retired_o increments, wrapping modulo 2^CNT_W.
  - Next state is FETCH if start_i = 1, else IDLE.
  - Deasserting start_i mid-instruction never aborts the instruction; it completes.
- Latency with zero-wait memory (ack in the first request cycle):
  - j: 2 cycles
  - beq: 3 cycles
  - R-type, addi, sw: 4 cycles
  - lw: 5 cycles
- Wait counter:
  - Increments each cycle spent in FETCH or MEM without the matching ack.
  - Clears on state change.
  - If it reaches WAIT_MAX with no ack: go to HALT and set err_o.
  - An ack in the same cycle the count reaches WAIT_MAX wins: no trap.
- HALT: every control output is 0 and busy_o = 0. The state is left only by reset; err_o stays 1.
- Ack inputs in non-waiting states are ignored.

Test Plan:
- Reset, then start_i = 1 with zero-wait acks and an R-type instruction -> state sequence 1, 2, 3, 5, then 1. reg_we_o = 1 and reg_dst_o = 1 only in WB. retired_o = 1 after 4 cycles.
- lw with dmem_ack_i delayed 3 cycles -> MEM lasts 4 cycles with dmem_req_o = 1 and dmem_we_o = 0. WB has mem_to_reg_o = 1. Total 8 cycles.
- beq with zero_i = 1, then with zero_i = 0 -> pc_we_o = 1 with pc_src_o = 01 in EXEC only when zero_i = 1. retired_o increments in both cases.
- Drop start_i during EXEC of sw -> MEM completes with dmem_we_o = 1, then state goes to IDLE (0), busy_o = 0, retired_o increments.
- op_i = 111111 in DECODE -> state HALT (6), err_o = 1 and stays 1 despite start_i. rst_i = 0 clears it asynchronously.
- Hold imem_ack_i = 0 with WAIT_MAX = 4 -> HALT after 4 FETCH cycles. A second run with ack on the 4th cycle -> no trap, state goes to DECODE.
